// File: rtl/operand_dispatch_ctrl.sv
// rtl/operand_dispatch_ctrl.sv - issue scheduler for ADD/MULT/MULADD units with per-unit watchdog
module operand_dispatch_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [1:0]        issue_op,
    input  logic [DATA_W-1:0] source_1_value,
    input  logic [DATA_W-1:0] source_2_value,
    input  logic [DATA_W-1:0] source_3_value,
    output logic              add_start,
    output logic              mult_start,
    output logic              muladd_start,
    output logic [DATA_W-1:0] add_src1,
    output logic [DATA_W-1:0] add_src2,
    output logic [DATA_W-1:0] mult_src1,
    output logic [DATA_W-1:0] mult_src2,
    output logic [DATA_W-1:0] muladd_src1,
    output logic [DATA_W-1:0] muladd_src2,
    output logic [DATA_W-1:0] muladd_src3,
    input  logic              add_done,
    input  logic              mult_done,
    input  logic              muladd_done,
    output logic [1:0]        source1_sel,
    output logic [2:0]        busy_vec,
    output logic              op_err,
    output logic [2:0]        timeout_err
);

    localparam logic [1:0]       OP_ILLEGAL = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    logic [2:0]       busy_q;
    logic [2:0]       start_q;
    logic [2:0]       tout_q;
    logic [CNT_W-1:0] cnt_q [3];
    logic [1:0]       sel_q;
    logic             op_err_q;

    logic       legal;
    logic       accept;
    logic [2:0] launch;
    logic [2:0] done_vec;
    logic [2:0] retire;
    logic [2:0] expire;

    assign done_vec = {muladd_done, mult_done, add_done};

    // Handshake decode: a legal op waits for its unit; an illegal op is always consumed.
    always_comb begin
        legal       = (issue_op != OP_ILLEGAL);
        issue_ready = rst_n & (legal ? ~busy_q[issue_op] : 1'b1);
        accept      = issue_valid & issue_ready;
        launch      = 3'b000;
        if (accept && legal) begin
            launch[issue_op] = 1'b1;
        end
    end

    // Per-unit release: done is only trusted once the start pulse is over; watchdog yields to done.
    always_comb begin
        retire = 3'b000;
        expire = 3'b000;
        for (int u = 0; u < 3; u++) begin
            retire[u] = busy_q[u] & done_vec[u] & ~start_q[u];
            expire[u] = busy_q[u] & ~retire[u] & (cnt_q[u] == CNT_LAST);
        end
    end

    // Busy flags, watchdog counters and the single-cycle pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 3'b000;
            start_q  <= 3'b000;
            tout_q   <= 3'b000;
            op_err_q <= 1'b0;
            for (int u = 0; u < 3; u++) begin
                cnt_q[u] <= '0;
            end
        end else begin
            start_q  <= launch;
            tout_q   <= expire;
            op_err_q <= accept & ~legal;
            for (int u = 0; u < 3; u++) begin
                if (launch[u]) begin
                    busy_q[u] <= 1'b1;
                    cnt_q[u]  <= '0;
                end else if (retire[u] || expire[u]) begin
                    busy_q[u] <= 1'b0;
                    cnt_q[u]  <= '0;
                end else if (busy_q[u]) begin
                    cnt_q[u]  <= cnt_q[u] + CNT_W'(1);
                end
            end
        end
    end

    // Operand capture: only the launched unit's registers load; all others hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_src1    <= '0;
            add_src2    <= '0;
            mult_src1   <= '0;
            mult_src2   <= '0;
            muladd_src1 <= '0;
            muladd_src2 <= '0;
            muladd_src3 <= '0;
            sel_q       <= 2'b00;
        end else begin
            if (launch[0]) begin
                add_src1 <= source_1_value;
                add_src2 <= source_2_value;
            end
            if (launch[1]) begin
                mult_src1 <= source_1_value;
                mult_src2 <= source_2_value;
            end
            if (launch[2]) begin
                muladd_src1 <= source_1_value;
                muladd_src2 <= source_2_value;
                muladd_src3 <= source_3_value;
            end
            if (accept && legal) begin
                sel_q <= issue_op;
            end
        end
    end

    assign add_start    = start_q[0];
    assign mult_start   = start_q[1];
    assign muladd_start = start_q[2];
    assign busy_vec     = busy_q;
    assign timeout_err  = tout_q;
    assign op_err       = op_err_q;
    assign source1_sel  = sel_q;

endmodule
